// File: rtl/matrix_pkg.sv
// Shared constants, loader state type and element-offset helper for the 5x5 matrix datapath.
package matrix_pkg;

    localparam int unsigned N        = 5;
    localparam int unsigned W        = 8;
    localparam int unsigned MAT_BITS = N * N * W;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } ld_state_e;

    // One past the MSB of element (i,j) in a row-major packed operand.
    function automatic int unsigned elem_off(input int unsigned i, input int unsigned j);
        return MAT_BITS - N * W * i - W * j;
    endfunction

endpackage

// File: rtl/mat_idx_cnt.sv
// Row/column index counter over an N x N grid; wraps (N-1,N-1) -> (0,0) and flags the last cell.
module mat_idx_cnt
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       done
);

    localparam logic [2:0] LAST = 3'(N - 1);

    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign done = (row_q == LAST) && (col_q == LAST);

endmodule

// File: rtl/matrix_loader.sv
// Operand loader: packs A row-major into lin and B transposed into col, then holds them for the multiplier.
// Optional MATRIX_LOADER_REUSE_EN adds reuse_b to skip reloading B.
module matrix_loader #(
    parameter int unsigned N = matrix_pkg::N,
    parameter int unsigned W = matrix_pkg::W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [W-1:0]   in_data,
`ifdef MATRIX_LOADER_REUSE_EN
    input  logic                  reuse_b,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*N*W-1:0]      lin,
    output logic [N*N*W-1:0]      col,
    output logic [5:0]            elem_cnt
);
    import matrix_pkg::*;

    ld_state_e          state_q, state_d;
    logic [N*N*W-1:0]   lin_q, lin_d;
    logic [N*N*W-1:0]   col_q, col_d;
    logic [5:0]         cnt_q, cnt_d;

    logic [2:0] row_idx, col_idx;
    logic       idx_done;
    logic       inc;
    logic       skip_b;
    logic [7:0] lo_a, lo_b;

`ifdef MATRIX_LOADER_REUSE_EN
    assign skip_b = reuse_b;
`else
    assign skip_b = 1'b0;
`endif

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign inc       = in_valid && in_ready && !clr;

    // B is placed transposed, so its offset swaps the row/column roles.
    assign lo_a = 8'(elem_off(32'(row_idx), 32'(col_idx)) - W);
    assign lo_b = 8'(elem_off(32'(col_idx), 32'(row_idx)) - W);

    mat_idx_cnt u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (inc),
        .row  (row_idx),
        .col  (col_idx),
        .done (idx_done)
    );

    always_comb begin
        state_d = state_q;
        lin_d   = lin_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = LOAD_A;
            cnt_d   = '0;
        end else begin
            if (inc) begin
                cnt_d = cnt_q + 6'd1;
                if (state_q == LOAD_A) lin_d[lo_a +: W] = in_data;
                else                   col_d[lo_b +: W] = in_data;
            end
            case (state_q)
                LOAD_A: if (inc && idx_done) state_d = skip_b ? HOLD : LOAD_B;
                LOAD_B: if (inc && idx_done) state_d = HOLD;
                HOLD: begin
                    if (out_ready) begin
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD_A;
            lin_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lin_q   <= lin_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lin      = lin_q;
    assign col      = col_q;
    assign elem_cnt = cnt_q;

endmodule
